sd_ramdisk: RTL and testbench

Storage Device that answers the disk-controller storage protocol: command_ready / read_cmd / write_cmd handshake, fifo_clk-paced block transfer, write_data_enable / read_data_enable framing. It sits on one port of the storage-device multiplexer and holds an on-chip RAM of fixed-size blocks. It serves as the reference device for controller bring-up and simulation.

---
 rtl/sd_ramdisk.sv | 173 +++++++++++++++++
 tb/tb_sd_ramdisk.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_ramdisk.sv
// rtl/sd_ramdisk.sv - on-chip RAM storage device speaking the controller block-transfer protocol
// Serves fixed-size blocks over a fifo_clk-paced handshake; every output is registered.
module sd_ramdisk #(
    parameter  int BLOCKS       = 64,
    parameter  int BLOCK_WORDS  = 256,
    // one extra code point so out-of-range block numbers reach the device and can be rejected
    localparam int BLOCK_ADDR_W = $clog2(BLOCKS + 1),
    localparam int WORD_W       = $clog2(BLOCK_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    command_ready,
    input  logic                    read_cmd,
    input  logic                    write_cmd,
    input  logic [BLOCK_ADDR_W-1:0] block_addr,
    output logic                    fifo_clk,
    output logic                    write_data_enable,
    input  logic [15:0]             write_data,
    output logic [15:0]             read_data,
    output logic                    read_data_enable,
    output logic                    error
);

    localparam int                    IDX_W     = $clog2(BLOCKS);
    localparam int                    DEPTH     = BLOCKS * BLOCK_WORDS;
    localparam logic [BLOCK_ADDR_W-1:0] BLOCKS_V  = BLOCK_ADDR_W'(BLOCKS);
    localparam logic [WORD_W-1:0]       LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_FETCH = 2'd1,
        RD_XFER  = 2'd2,
        WR_XFER  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    blk, blk_d;
    logic [WORD_W-1:0]   cnt, cnt_d;
    logic                phase, phase_d;
    logic                last, last_d;
    logic                ready_d, fifo_d, wde_d, rde_d, err_d;
    logic [15:0]         rdata_d;
    logic                mem_we;
    logic [15:0]         ram_q;
    logic [15:0]         mem [DEPTH];
    logic [IDX_W+WORD_W-1:0] mem_addr;

    assign mem_addr = {blk, cnt};

    // RAM contents survive reset so an aborted write keeps its partial block
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= write_data;
        end
        ram_q <= mem[mem_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            blk               <= '0;
            cnt               <= '0;
            phase             <= 1'b0;
            last              <= 1'b0;
            command_ready     <= 1'b0;
            fifo_clk          <= 1'b0;
            write_data_enable <= 1'b0;
            read_data_enable  <= 1'b0;
            read_data         <= '0;
            error             <= 1'b0;
        end else begin
            state             <= state_d;
            blk               <= blk_d;
            cnt               <= cnt_d;
            phase             <= phase_d;
            last              <= last_d;
            command_ready     <= ready_d;
            fifo_clk          <= fifo_d;
            write_data_enable <= wde_d;
            read_data_enable  <= rde_d;
            read_data         <= rdata_d;
            error             <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        blk_d   = blk;
        cnt_d   = cnt;
        phase_d = phase;
        last_d  = last;
        ready_d = command_ready;
        fifo_d  = fifo_clk;
        wde_d   = write_data_enable;
        rde_d   = read_data_enable;
        rdata_d = read_data;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state)
            IDLE: begin
                ready_d = 1'b1;
                fifo_d  = 1'b0;
                wde_d   = 1'b0;
                rde_d   = 1'b0;
                if (command_ready && (read_cmd || write_cmd)) begin
                    if ((read_cmd && write_cmd) || (block_addr >= BLOCKS_V)) begin
                        err_d = 1'b1;
                    end else begin
                        blk_d   = block_addr[IDX_W-1:0];
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        state_d = read_cmd ? RD_FETCH : WR_XFER;
                    end
                end
            end

            RD_FETCH: begin
                phase_d = 1'b1;
                last_d  = 1'b0;
                fifo_d  = 1'b0;
                state_d = RD_XFER;
            end

            // phase=1 marks a falling fifo_clk edge: present the prefetched word
            RD_XFER: begin
                if (phase) begin
                    fifo_d  = 1'b0;
                    phase_d = 1'b0;
                    if (last) begin
                        rde_d   = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rdata_d = ram_q;
                        rde_d   = 1'b1;
                        if (cnt == LAST_WORD) begin
                            last_d = 1'b1;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end else begin
                    fifo_d  = 1'b1;
                    phase_d = 1'b1;
                end
            end

            WR_XFER: begin
                if (!write_data_enable) begin
                    wde_d = 1'b1;
                end else if (!fifo_clk) begin
                    fifo_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    fifo_d = 1'b0;
                    if (cnt == LAST_WORD) begin
                        wde_d   = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_ramdisk.sv
// tb/tb_sd_ramdisk.sv - directed scoreboard bench for sd_ramdisk
// A bench-side block model supplies every expected read word and transfer edge number.
module tb_sd_ramdisk;

    localparam int N = 256;

    logic        clk;
    logic        reset_n;
    logic        command_ready;
    logic        read_cmd;
    logic        write_cmd;
    logic [6:0]  block_addr;
    logic        fifo_clk;
    logic        write_data_enable;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_data_enable;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [64][N];
    logic [15:0] wbuf [N];
    logic [15:0] exp_q [$];

    sd_ramdisk dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .command_ready     (command_ready),
        .read_cmd          (read_cmd),
        .write_cmd         (write_cmd),
        .block_addr        (block_addr),
        .fifo_clk          (fifo_clk),
        .write_data_enable (write_data_enable),
        .write_data        (write_data),
        .read_data         (read_data),
        .read_data_enable  (read_data_enable),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_ready"}, 32'(command_ready), 32'd0);
        check({tag, "_fifo"},  32'(fifo_clk), 32'd0);
        check({tag, "_wde"},   32'(write_data_enable), 32'd0);
        check({tag, "_rde"},   32'(read_data_enable), 32'd0);
        check({tag, "_rdata"}, 32'(read_data), 32'd0);
        check({tag, "_err"},   32'(error), 32'd0);
    endtask

    task automatic fill(input int kind, input logic [15:0] base);
        for (int i = 0; i < N; i++) wbuf[i] = (kind == 0) ? base : base + 16'(i);
    endtask

    // Issue one command from a post-edge sample point and follow it to completion.
    // abort_at >= 0 asserts reset right after the fifo_clk rise of that write word.
    task automatic run_cmd(input logic rd, input int blk, input int abort_at, input logic poke);
        int k, rises;
        logic prev_fifo, err_seen, done, aborted;
        logic [15:0] e;
        read_cmd   = rd;
        write_cmd  = !rd;
        block_addr = 7'(blk);
        @(posedge clk);
        #1;
        read_cmd  = 1'b0;
        write_cmd = 1'b0;
        check("accept_ready_drop", 32'(command_ready), 32'd0);
        if (rd) for (int i = 0; i < N; i++) exp_q.push_back(model[blk][i]);
        k = 0; rises = 0; prev_fifo = fifo_clk; err_seen = 0; done = 0; aborted = 0;
        while (!done && k < 1200) begin
            @(posedge clk);
            #1;
            k++;
            if (error) err_seen = 1'b1;
            if (poke && k == 50) write_cmd = 1'b1;
            if (poke && k == 51) write_cmd = 1'b0;
            if (fifo_clk && !prev_fifo) begin
                if (rd) begin
                    check("rd_rise_edge", 32'(k), 32'(3 + 2 * rises));
                    check("rd_enable", 32'(read_data_enable), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("rd_queue_underflow", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", 32'(read_data), 32'(e));
                    end
                end else begin
                    check("wr_rise_edge", 32'(k), 32'(2 + 2 * rises));
                    check("wr_enable", 32'(write_data_enable), 32'd1);
                    if (rises < N) write_data = wbuf[rises];
                    if (rises == abort_at) begin
                        reset_n = 1'b0;
                        #1;
                        check_all_clear("abort");
                        for (int i = 0; i < abort_at; i++) model[blk][i] = wbuf[i];
                        aborted = 1'b1;
                        done    = 1'b1;
                    end
                end
                rises++;
            end
            prev_fifo = fifo_clk;
            if (command_ready) done = 1'b1;
        end
        if (aborted) begin
            @(negedge clk);
            reset_n = 1'b1;
            @(posedge clk);
            #1;
            check("abort_ready_back", 32'(command_ready), 32'd1);
        end else begin
            check(rd ? "rd_ready_edge" : "wr_ready_edge", 32'(k), rd ? 32'(2 * N + 2) : 32'(2 * N + 1));
            check("xfer_rises", 32'(rises), 32'(N));
            check("xfer_no_error", 32'(err_seen), 32'd0);
            check("end_fifo_low", 32'(fifo_clk), 32'd0);
            check("end_enables_low", 32'({write_data_enable, read_data_enable}), 32'd0);
            if (rd) begin
                check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end else begin
                for (int i = 0; i < N; i++) model[blk][i] = wbuf[i];
            end
        end
    endtask

    task automatic reject(input logic rd, input logic wr, input int blk, input string tag);
        read_cmd   = rd;
        write_cmd  = wr;
        block_addr = 7'(blk);
        @(posedge clk);
        #1;
        read_cmd  = 1'b0;
        write_cmd = 1'b0;
        check({tag, "_err_pulse"}, 32'(error), 32'd1);
        check({tag, "_ready_held"}, 32'(command_ready), 32'd1);
        check({tag, "_fifo_idle"}, 32'(fifo_clk), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_err_end"}, 32'(error), 32'd0);
        check({tag, "_ready_after"}, 32'(command_ready), 32'd1);
        check({tag, "_no_xfer"}, 32'({fifo_clk, write_data_enable, read_data_enable}), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        read_cmd   = 1'b0;
        write_cmd  = 1'b0;
        block_addr = '0;
        write_data = '0;

        #23;
        check_all_clear("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_ready_before_edge", 32'(command_ready), 32'd0);
        @(posedge clk);
        #1;
        check("release_ready", 32'(command_ready), 32'd1);
        check("release_fifo", 32'(fifo_clk), 32'd0);

        fill(1, 16'h1000);
        run_cmd(1'b0, 5, -1, 1'b0);
        run_cmd(1'b1, 5, -1, 1'b0);

        fill(0, 16'hAAAA);
        run_cmd(1'b0, 0, -1, 1'b0);
        fill(0, 16'h5555);
        run_cmd(1'b0, 63, -1, 1'b0);
        run_cmd(1'b1, 0, -1, 1'b0);
        run_cmd(1'b1, 63, -1, 1'b0);

        reject(1'b1, 1'b1, 5, "rej_both");
        reject(1'b1, 1'b0, 64, "rej_addr_rd");
        reject(1'b0, 1'b1, 64, "rej_addr_wr");

        run_cmd(1'b1, 5, -1, 1'b1);

        fill(1, 16'h7000);
        run_cmd(1'b0, 7, -1, 1'b0);
        fill(1, 16'hB000);
        run_cmd(1'b0, 7, 100, 1'b0);
        run_cmd(1'b1, 7, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
